// File: rtl/data_plane_tx.sv
// Data-plane transmit stage: buffers GPP words and, on a control-plane grant, emits a
// registered burst of PACKET_LEN {dest,data} packets followed by a one-cycle complete pulse.
module data_plane_tx #(
  parameter int          DEPTH      = 16,
  parameter int          PACKET_LEN = 5,
  parameter logic [15:0] IDLE_ID    = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              gpp_data_in,
  input  logic                     gpp_wr_tx,
  input  logic                     tx_start,
  input  logic [15:0]              dest_id,
  output logic [31:0]              data_tx_packet,
  output logic                     tx_busy,
  output logic                     data_tx_complete_flag,
  output logic                     tx_reject,
  output logic                     tx_overflow,
  output logic                     tx_buf_full,
  output logic                     tx_buf_empty,
  output logic [$clog2(DEPTH):0]   tx_word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(PACKET_LEN + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_LEN_C  = CW'(PACKET_LEN);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PACKET_LEN - 1);
  localparam logic [31:0]   IDLE_PKT   = {IDLE_ID, 16'h0000};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic [15:0]   dest_q;

  logic          pop;
  logic          push_ok;
  logic          start_ok;
  logic          start_bad;
  logic [CW-1:0] count_next;

  // A burst only starts with PACKET_LEN words buffered and pushes only add, so SEND never underruns.
  always_comb begin
    pop        = (state == ST_SEND);
    push_ok    = gpp_wr_tx && ((tx_word_count != DEPTH_C) || pop);
    start_ok   = (state == ST_IDLE) && tx_start &&
                 (tx_word_count >= PKT_LEN_C) && (dest_id != IDLE_ID);
    start_bad  = (state == ST_IDLE) && tx_start && !start_ok;
    count_next = tx_word_count;
    case ({push_ok, pop})
      2'b10:   count_next = tx_word_count + CW'(1);
      2'b01:   count_next = tx_word_count - CW'(1);
      default: count_next = tx_word_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= gpp_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      tx_word_count         <= '0;
      tx_buf_full           <= 1'b0;
      tx_buf_empty          <= 1'b1;
      state                 <= ST_IDLE;
      beat                  <= '0;
      dest_q                <= IDLE_ID;
      data_tx_packet        <= IDLE_PKT;
      tx_busy               <= 1'b0;
      data_tx_complete_flag <= 1'b0;
      tx_reject             <= 1'b0;
      tx_overflow           <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      tx_word_count         <= count_next;
      tx_buf_full           <= (count_next == DEPTH_C);
      tx_buf_empty          <= (count_next == '0);
      tx_overflow           <= gpp_wr_tx && !push_ok;
      tx_reject             <= start_bad;
      data_tx_complete_flag <= 1'b0;
      // Busy lags the state by one edge so it covers the cycle after DONE as well.
      tx_busy               <= (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          data_tx_packet <= IDLE_PKT;
          if (start_ok) begin
            dest_q <= dest_id;
            beat   <= '0;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          data_tx_packet <= {dest_q, mem[rd_ptr]};
          beat           <= beat + BW'(1);
          if (beat == LAST_BEAT) state <= ST_DONE;
        end
        ST_DONE: begin
          data_tx_packet        <= IDLE_PKT;
          data_tx_complete_flag <= 1'b1;
          state                 <= ST_IDLE;
        end
        default: begin
          data_tx_packet <= IDLE_PKT;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_plane_tx.sv
// Randomized and directed bench for data_plane_tx against a queue/timeline reference model.
module tb_data_plane_tx;

  localparam int          DEPTH   = 16;
  localparam int          PL      = 5;
  localparam logic [15:0] IDLE_ID = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpp_data_in;
  logic        gpp_wr_tx;
  logic        tx_start;
  logic [15:0] dest_id;
  logic [31:0] data_tx_packet;
  logic        tx_busy;
  logic        data_tx_complete_flag;
  logic        tx_reject;
  logic        tx_overflow;
  logic        tx_buf_full;
  logic        tx_buf_empty;
  logic [4:0]  tx_word_count;

  always #5 clk = ~clk;

  data_plane_tx #(.DEPTH(DEPTH), .PACKET_LEN(PL), .IDLE_ID(IDLE_ID)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .gpp_data_in           (gpp_data_in),
    .gpp_wr_tx             (gpp_wr_tx),
    .tx_start              (tx_start),
    .dest_id               (dest_id),
    .data_tx_packet        (data_tx_packet),
    .tx_busy               (tx_busy),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_reject             (tx_reject),
    .tx_overflow           (tx_overflow),
    .tx_buf_full           (tx_buf_full),
    .tx_buf_empty          (tx_buf_empty),
    .tx_word_count         (tx_word_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a word queue plus the edge number of the accepted grant.
  logic [15:0] q[$];
  int          edge_no    = 0;
  bit          active     = 0;
  int          start_edge = 0;
  int          free_edge  = 0;
  logic [15:0] m_dest     = 16'h0;
  logic [31:0] exp_pkt    = {16'hFFFF, 16'h0};
  bit          exp_busy, exp_cmp, exp_rej, exp_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int cnt;
    int rel;
    bit popping;
    edge_no++;
    exp_busy = 0; exp_cmp = 0; exp_rej = 0; exp_ovf = 0;
    exp_pkt  = {IDLE_ID, 16'h0};
    if (rst) begin
      q.delete();
      active    = 0;
      free_edge = 0;
      return;
    end
    cnt     = q.size();
    rel     = edge_no - start_edge;
    popping = active && rel >= 1 && rel <= PL;
    if (popping) exp_pkt = {m_dest, q.pop_front()};
    if (gpp_wr_tx) begin
      if (cnt < DEPTH || popping) q.push_back(gpp_data_in);
      else exp_ovf = 1;
    end
    exp_cmp  = active && rel == PL + 1;
    exp_busy = active && rel >= 1 && rel <= PL + 1;
    if (tx_start && edge_no >= free_edge) begin
      if (cnt >= PL && dest_id != IDLE_ID) begin
        active     = 1;
        start_edge = edge_no;
        free_edge  = edge_no + PL + 2;
        m_dest     = dest_id;
      end else begin
        exp_rej = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("packet",   data_tx_packet,        exp_pkt);
    chk("busy",     32'(tx_busy),          32'(exp_busy));
    chk("complete", 32'(data_tx_complete_flag), 32'(exp_cmp));
    chk("reject",   32'(tx_reject),        32'(exp_rej));
    chk("overflow", 32'(tx_overflow),      32'(exp_ovf));
    chk("count",    32'(tx_word_count),    32'(q.size()));
    chk("full",     32'(tx_buf_full),      32'(q.size() == DEPTH));
    chk("empty",    32'(tx_buf_empty),     32'(q.size() == 0));
  endtask

  task automatic cyc(input bit r, input bit wr, input logic [15:0] d,
                     input bit st, input logic [15:0] did);
    rst = r; gpp_wr_tx = wr; gpp_data_in = d; tx_start = st; dest_id = did;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic push(input logic [15:0] d);
    cyc(0, 1, d, 0, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic start(input logic [15:0] did);
    cyc(0, 0, 16'h0, 1, did);
  endtask

  task automatic do_reset();
    cyc(1, 0, 16'h0, 0, 16'h0);
    cyc(1, 0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    do_reset();
    idle(1);

    // Basic burst to dest 3.
    for (int i = 1; i <= 5; i++) push(16'(i * 16'h11));
    start(16'd3);
    idle(8);

    // Too few words, then the reserved idle id.
    for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i));
    start(16'd3);
    idle(2);
    push(16'h0204);
    start(IDLE_ID);
    idle(2);
    start(16'd7);
    idle(8);

    // Overfill by one word, then drain most of it.
    for (int i = 0; i < 17; i++) push(16'h0300 + 16'(i));
    idle(2);
    for (int b = 0; b < 3; b++) begin
      start(16'(b + 10));
      idle(7);
    end
    do_reset();

    // Push during SEND; restart refused until five words are present.
    for (int i = 0; i < 5; i++) push(16'h0400 + 16'(i));
    start(16'd4);
    idle(1);
    push(16'h00AA);
    idle(6);
    start(16'd4);
    for (int i = 0; i < 4; i++) begin
      push(16'h0410 + 16'(i));
      start(16'd4);
    end
    idle(8);
    do_reset();

    // Reset on the third SEND edge.
    for (int i = 0; i < 5; i++) push(16'h0500 + 16'(i));
    start(16'd5);
    idle(2);
    cyc(1, 0, 16'h0, 0, 16'h0);
    idle(8);

    // Back-to-back bursts with refills so the pointers wrap.
    for (int i = 0; i < 5; i++) push(16'h0600 + 16'(i));
    for (int b = 0; b < 4; b++) begin
      start(16'(b + 1));
      for (int i = 0; i < 5; i++) push(16'h0610 + 16'(b * 16 + i));
      idle(1);
    end
    idle(8);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          r, wr, st;
      logic [15:0] did;
      r   = ($urandom_range(0, 399) == 0);
      wr  = ($urandom_range(0, 99) < 55);
      st  = ($urandom_range(0, 5) == 0);
      did = ($urandom_range(0, 7) == 0) ? IDLE_ID : 16'($urandom_range(0, 15));
      cyc(r, wr, 16'($urandom), st, did);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
